// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The master side is the byte source plus the memory; the slave side is the loader.
interface imem_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory from address 0 and holds the core in reset until done.
module imem_loader #(
  parameter int unsigned WORD_ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_ADDR_W:0] word_count,
  imem_loader_if.slave         bus,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [WORD_ADDR_W:0]   DEPTH_CNT = {1'b1, {WORD_ADDR_W{1'b0}}};
  localparam logic [WORD_ADDR_W:0]   ONE_CNT   = {{WORD_ADDR_W{1'b0}}, 1'b1};
  localparam logic [WORD_ADDR_W-1:0] ONE_IDX   = {{(WORD_ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [WORD_ADDR_W:0]   count;
  logic [WORD_ADDR_W-1:0] index;
  logic [1:0]             byte_cnt;
  logic [23:0]            lanes;
  logic [63:0]            addr_q;
  logic [31:0]            wdata_q;

  logic start_ok;
  logic can_start;
  logic accept;
  logic take;
  logic last_word;

  assign start_ok  = (word_count != '0) && (word_count <= DEPTH_CNT);
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign accept    = can_start && start && start_ok;
  assign take      = (state == S_COLLECT) && bus.byte_valid;
  assign last_word = (({1'b0, index}) + ONE_CNT) == count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    bus.byte_ready = 1'b0;
    bus.imem_we    = 1'b0;
    core_reset     = 1'b1;
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = start_ok ? S_COLLECT : S_ERR;
      end
      S_COLLECT: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (take && (byte_cnt == 2'd3)) state_nx = S_WRITE;
      end
      S_WRITE: begin
        bus.imem_we = 1'b1;
        busy        = 1'b1;
        state_nx    = last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        done       = 1'b1;
        core_reset = 1'b0;
        if (start) state_nx = start_ok ? S_COLLECT : S_ERR;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nx = start_ok ? S_COLLECT : S_ERR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Address and data are captured with the 4th byte so they are stable through the
  // whole WRITE cycle and simply hold afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      index    <= '0;
      byte_cnt <= '0;
      lanes    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (accept) begin
        count    <= word_count;
        index    <= '0;
        byte_cnt <= '0;
      end
      if (take) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: lanes[7:0]   <= bus.byte_in;
          2'd1: lanes[15:8]  <= bus.byte_in;
          2'd2: lanes[23:16] <= bus.byte_in;
          default: begin
            addr_q  <= {{(62-WORD_ADDR_W){1'b0}}, index, 2'b00};
            wdata_q <= {bus.byte_in, lanes};
          end
        endcase
      end
      if ((state == S_WRITE) && !last_word) begin
        index <= index + ONE_IDX;
      end
    end
  end

  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader for the pipelined RISC-V core: accepts a little-endian byte stream over a valid/ready handshake, packs it into 32-bit instruction words, writes them sequentially into instruction memory from byte address 0, and holds the core in reset until the image is complete. It is the writer side of instruction memory, whose only other user is the core's fetch stage.

## Interface
- WORD_ADDR_W, 6: instruction-memory word-address width; capacity DEPTH = 2^WORD_ADDR_W words.
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; forces the reset state immediately.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
- word_count  in  WORD_ADDR_W+1  number of words to load; latched when start is accepted.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  64  byte address of the write (word index × 4).
- imem_wdata  out  32  assembled instruction word.
- core_reset  out  1  active-high reset to the core; 1 while loading or in error.
- busy  out  1  load in progress (COLLECT or WRITE).
- done  out  1  last load completed successfully.
- err  out  1  last start was rejected.

## Operation
- States: IDLE, COLLECT, WRITE, DONE, ERR.
- IDLE: byte_ready=0, core_reset=1. On start: if word_count==0 or word_count>DEPTH, go to ERR; otherwise latch word_count, clear word index and byte counter, and go to COLLECT.
- COLLECT: byte_ready=1. Each accepted byte goes into lane byte_cnt (first byte → bits [7:0], fourth → [31:24]). When the 4th byte is accepted, byte_cnt returns to 0 and the state goes to WRITE.
- WRITE: byte_ready=0 and imem_we=1 for exactly one cycle, with imem_addr = {index, 2'b00} zero-extended to 64 bits and imem_wdata = the assembled word. If index+1 == latched count, go to DONE; otherwise increment index and return to COLLECT.
- DONE: done=1, core_reset=0, busy=0. A start re-enters the IDLE start check: done clears and core_reset reasserts on the next cycle.
- ERR: err=1, core_reset=1. A start re-runs the check; a valid start clears err.
- start during COLLECT or WRITE is ignored. word_count changes after latching have no effect.
- byte_valid while byte_ready=0 is never consumed; the source must hold the byte.
- Index never wraps. The count check guarantees that the maximum address is (DEPTH−1)×4.
- Reset mid-load: asynchronous return to IDLE, partial word discarded, core_reset=1 immediately. Memory contents already written are not cleared.

## Timing
- Reset values: state IDLE, byte_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, busy 0, done 0, err 0.
- All outputs are registered or decoded directly from state; no combinational path from byte_valid to any output.
- start accepted at edge N: busy=1 and byte_ready=1 from cycle N+1.
- 4th byte accepted at edge M: imem_we=1 during cycle M+1 and byte_ready=0 in that cycle; byte_ready returns to 1 at M+2.
- Throughput: at most one word per 5 cycles with byte_valid held high.
- Last write strobe in cycle W: done=1 and core_reset=0 from cycle W+1.
- imem_addr and imem_wdata hold their last values when imem_we=0.

## Test plan
- Reset then idle: release reset with start=0 for 10 cycles → core_reset=1, byte_ready=0, imem_we=0, done=0, err=0 throughout.
- Two-word load, continuous valid: word_count=2, bytes 13,00,00,00,B3,80,20,00 → writes 0x00000013 at address 0 and 0x002080B3 at address 4, each imem_we pulse exactly one cycle, strobes 5 cycles apart; done=1 and core_reset=0 one cycle after the second strobe.
- Gapped stream: same image with byte_valid low for 3 cycles between each byte → identical writes; no byte is duplicated or dropped.
- Bad count: start with word_count=0, then again with word_count=DEPTH+1 (65) → ERR, err=1, no imem_we, core_reset=1; a following start with word_count=1 and bytes 6F,00,00,00 → 0x0000006F at address 0, err=0, done=1.
- Full depth: word_count=64 → last write at address 0xFC, then done; start during the load is ignored.
- Reset mid-word: assert reset after 2 bytes of word 1 → immediate IDLE, no imem_we for the partial word; a fresh load restarts at address 0.
